ysyx_25030093_lsu: RTL and testbench

Load/store stage directly downstream of the execute stage in the multi-cycle NPC core. Accepts the execute result (effective address or ALU result), rs2 store data and a memory-op code over a valid/ready handshake. Runs at most one data-memory transaction through a request/response port, then aligns and sign/zero-extends load data. Presents the write-back value to the write-back stage over a second valid/ready handshake.

---
 rtl/ysyx_25030093_lsu.sv | 169 ++++++++++++++++
 tb/tb_ysyx_25030093_lsu.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_lsu.sv
// Load/store stage: one data-memory transaction per instruction,
// with byte-lane steering for stores and extraction/extension for loads.
module ysyx_25030093_lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        lsu_op,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] rs2_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              misalign,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_bvalid
);

   localparam logic [3:0] OP_LB  = 4'b0001;
   localparam logic [3:0] OP_LH  = 4'b0010;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1010;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic [3:0]        op_q;
   logic [1:0]        off_q;
   logic              is_load;
   logic              is_store;
   logic              is_none;
   logic              is_mis;
   logic [DATA_W-1:0] wdata_nx;
   logic [3:0]        wmask_nx;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [DATA_W-1:0] load_val;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_mis   = 1'b0;
      wdata_nx = '0;
      wmask_nx = 4'b0000;
      unique case (lsu_op)
         OP_LB, OP_LBU: is_load = 1'b1;
         OP_LH, OP_LHU: begin
            is_load = 1'b1;
            is_mis  = alu_result[0];
         end
         OP_LW: begin
            is_load = 1'b1;
            is_mis  = |alu_result[1:0];
         end
         OP_SB: begin
            is_store = 1'b1;
            wdata_nx = {4{rs2_data[7:0]}};
            wmask_nx = 4'b0001 << alu_result[1:0];
         end
         OP_SH: begin
            is_store = 1'b1;
            is_mis   = alu_result[0];
            wdata_nx = {2{rs2_data[15:0]}};
            wmask_nx = alu_result[1] ? 4'b1100 : 4'b0011;
         end
         OP_SW: begin
            is_store = 1'b1;
            is_mis   = |alu_result[1:0];
            wdata_nx = rs2_data;
            wmask_nx = 4'b1111;
         end
         default: ;
      endcase
      is_none = !(is_load || is_store);
   end

   always_comb begin
      ld_b     = mem_rdata[{off_q, 3'b000} +: 8];
      ld_h     = mem_rdata[{off_q[1], 4'b0000} +: 16];
      load_val = '0;
      unique case (op_q)
         OP_LB:   load_val = {{24{ld_b[7]}}, ld_b};
         OP_LH:   load_val = {{16{ld_h[15]}}, ld_h};
         OP_LW:   load_val = mem_rdata;
         OP_LBU:  load_val = {24'b0, ld_b};
         OP_LHU:  load_val = {16'b0, ld_h};
         default: load_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      mem_req_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = (is_none || is_mis) ? DONE : REQ;
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nx = RESP;
         end
         RESP: begin
            // mem_wen doubles as the latched "this is a store" flag
            if (mem_wen ? mem_bvalid : mem_rvalid) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= 4'b0000;
         off_q     <= 2'b00;
         rd_data   <= '0;
         misalign  <= 1'b0;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= 4'b0000;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q      <= lsu_op;
                  off_q     <= alu_result[1:0];
                  misalign  <= is_mis;
                  rd_data   <= is_none ? alu_result : '0;
                  mem_wen   <= is_store;
                  mem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                  mem_wdata <= wdata_nx;
                  mem_wmask <= wmask_nx;
               end
            end
            RESP: begin
               if (!mem_wen && mem_rvalid) rd_data <= load_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Scenario bench for the LSU: per-feature tasks, expected results
// queued on issue and popped when out_valid is observed.
module tb_ysyx_25030093_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  lsu_op;
   logic [31:0] alu_result;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rd_data;
   logic        misalign;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_bvalid;

   typedef struct packed {
      logic [31:0] rd;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   req_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_req_valid) req_cnt <= req_cnt + 1;

   ysyx_25030093_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .lsu_op(lsu_op), .alu_result(alu_result), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .rd_data(rd_data), .misalign(misalign),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_bvalid(mem_bvalid)
   );

   function automatic logic [31:0] load_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a[1:0])
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (op)
         4'h1:    return {{24{b[7]}}, b};
         4'h2:    return {{16{h[15]}}, h};
         4'h3:    return w;
         4'h4:    return {24'h0, b};
         4'h5:    return {16'h0, h};
         default: return 32'h0;
      endcase
   endfunction

   // Called at a negedge in IDLE; returns one negedge after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] xrd,
                        input logic xmis);
      exp_t x;
      x.rd  = xrd;
      x.mis = xmis;
      sb_q.push_back(x);
      in_valid   = 1'b1;
      lsu_op     = op;
      alu_result = a;
      rs2_data   = d;
      @(negedge clk);
      in_valid = 1'b0;
      lsu_op   = 4'h0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
          mem_wen !== 1'b0 || misalign !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl got rdy=%b ov=%b rq=%b wen=%b mis=%b want 1 0 0 0 0",
                  in_ready, out_valid, mem_req_valid, mem_wen, misalign);
      end
      tests++;
      if (rd_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          mem_wmask !== 4'h0) begin
         fails++;
         $display("FAIL reset_data got rd=%h a=%h wd=%h m=%b want all zero",
                  rd_data, mem_addr, mem_wdata, mem_wmask);
      end
   endtask

   task automatic test_none;
      int c0;
      c0 = req_cnt;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL none_ready got %b want 1", in_ready);
      end
      issue(4'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
      e = sb_q.pop_front();
      tests++;
      if (out_valid !== 1'b1 || rd_data !== e.rd || misalign !== e.mis) begin
         fails++;
         $display("FAIL none_out got ov=%b rd=%h mis=%b want 1 %h %b",
                  out_valid, rd_data, misalign, e.rd, e.mis);
      end
      @(negedge clk);
      issue(4'h6, 32'hCAFE_0001, 32'h0, 32'hCAFE_0001, 1'b0);
      e = sb_q.pop_front();
      tests++;
      if (out_valid !== 1'b1 || rd_data !== e.rd || misalign !== e.mis) begin
         fails++;
         $display("FAIL bad_op_out got ov=%b rd=%h mis=%b want 1 %h %b",
                  out_valid, rd_data, misalign, e.rd, e.mis);
      end
      @(negedge clk);
      tests++;
      if (req_cnt !== c0) begin
         fails++;
         $display("FAIL none_noreq got %0d req cycles want 0", req_cnt - c0);
      end
   endtask

   task automatic do_load(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] w, input string nm);
      issue(op, a, 32'h5555_5555, load_model(op, a, w), 1'b0);
      tests++;
      if (mem_req_valid !== 1'b1 || mem_wen !== 1'b0 || mem_wmask !== 4'h0 ||
          mem_addr !== {a[31:2], 2'b00}) begin
         fails++;
         $display("FAIL %s_req got rq=%b wen=%b m=%b a=%h want 1 0 0000 %h",
                  nm, mem_req_valid, mem_wen, mem_wmask, mem_addr, {a[31:2], 2'b00});
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b1;
      mem_rdata     = w;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      e = sb_q.pop_front();
      tests++;
      if (out_valid !== 1'b1 || rd_data !== e.rd || misalign !== 1'b0) begin
         fails++;
         $display("FAIL %s_out got ov=%b rd=%h mis=%b want 1 %h 0",
                  nm, out_valid, rd_data, misalign, e.rd);
      end
      @(negedge clk);
   endtask

   task automatic test_loads;
      logic [3:0]  ops[5];
      logic [3:0]  op;
      logic [31:0] a;
      ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      do_load(4'h1, 32'h8000_0003, 32'h80AB_CDEF, "lb");
      tests++;
      if (rd_data !== 32'hFFFF_FF80) begin
         fails++;
         $display("FAIL lb_const got %h want ffffff80", rd_data);
      end
      do_load(4'h4, 32'h8000_0003, 32'h80AB_CDEF, "lbu");
      tests++;
      if (rd_data !== 32'h0000_0080) begin
         fails++;
         $display("FAIL lbu_const got %h want 00000080", rd_data);
      end
      for (int k = 0; k < 10; k++) begin
         op = ops[k % 5];
         a  = 32'h8000_0100 + 32'(k * 16);
         if (op == 4'h1 || op == 4'h4) a[1:0] = 2'(k);
         else if (op != 4'h3)          a[1]   = k[0];
         do_load(op, a, $urandom, "ld_rand");
      end
   endtask

   task automatic test_store;
      issue(4'h9, 32'h8000_0006, 32'hDEAD_BEEF, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 32'h8000_0004 ||
             mem_wdata !== 32'hBEEF_BEEF || mem_wmask !== 4'b1100) begin
            fails++;
            $display("FAIL sh_hold%0d got rq=%b wen=%b a=%h wd=%h m=%b want 1 1 80000004 beefbeef 1100",
                     i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
         end
         @(negedge clk);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      tests++;
      if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL sh_resp got rq=%b ov=%b want 0 0", mem_req_valid, out_valid);
      end
      mem_bvalid = 1'b1;
      @(negedge clk);
      mem_bvalid = 1'b0;
      e = sb_q.pop_front();
      tests++;
      if (out_valid !== 1'b1 || rd_data !== e.rd || misalign !== e.mis) begin
         fails++;
         $display("FAIL sh_out got ov=%b rd=%h mis=%b want 1 %h %b",
                  out_valid, rd_data, misalign, e.rd, e.mis);
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         issue(4'h8, 32'h9000_0000 + 32'(k), 32'h0000_00A5 + 32'(k << 8), 32'h0, 1'b0);
         tests++;
         if (mem_wmask !== (4'b0001 << k) || mem_wdata !== 32'hA5A5_A5A5 || mem_wen !== 1'b1) begin
            fails++;
            $display("FAIL sb_lane%0d got m=%b wd=%h wen=%b want %b a5a5a5a5 1",
                     k, mem_wmask, mem_wdata, mem_wen, 4'b0001 << k);
         end
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         mem_bvalid    = 1'b1;
         @(negedge clk);
         mem_bvalid = 1'b0;
         e = sb_q.pop_front();
         tests++;
         if (out_valid !== 1'b1 || rd_data !== e.rd) begin
            fails++;
            $display("FAIL sb_out%0d got ov=%b rd=%h want 1 %h", k, out_valid, rd_data, e.rd);
         end
         @(negedge clk);
      end
      issue(4'hA, 32'h9000_0010, 32'h1357_9BDF, 32'h0, 1'b0);
      tests++;
      if (mem_wmask !== 4'b1111 || mem_wdata !== 32'h1357_9BDF || mem_addr !== 32'h9000_0010) begin
         fails++;
         $display("FAIL sw_req got m=%b wd=%h a=%h want 1111 13579bdf 90000010",
                  mem_wmask, mem_wdata, mem_addr);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_bvalid    = 1'b1;
      @(negedge clk);
      mem_bvalid = 1'b0;
      e = sb_q.pop_front();
      tests++;
      if (out_valid !== 1'b1 || rd_data !== e.rd) begin
         fails++;
         $display("FAIL sw_out got ov=%b rd=%h want 1 %h", out_valid, rd_data, e.rd);
      end
      @(negedge clk);
   endtask

   task automatic test_misalign;
      logic [3:0]  ops[4];
      logic [31:0] as[4];
      int c0;
      ops = '{4'h3, 4'h2, 4'h9, 4'hA};
      as  = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0003, 32'h8000_0001};
      c0  = req_cnt;
      for (int k = 0; k < 4; k++) begin
         issue(ops[k], as[k], 32'hFFFF_FFFF, 32'h0, 1'b1);
         e = sb_q.pop_front();
         tests++;
         if (out_valid !== 1'b1 || misalign !== e.mis || rd_data !== e.rd) begin
            fails++;
            $display("FAIL misalign%0d got ov=%b mis=%b rd=%h want 1 %b %h",
                     k, out_valid, misalign, rd_data, e.mis, e.rd);
         end
         @(negedge clk);
      end
      tests++;
      if (req_cnt !== c0) begin
         fails++;
         $display("FAIL misalign_noreq got %0d req cycles want 0", req_cnt - c0);
      end
   endtask

   task automatic test_backpressure;
      issue(4'h2, 32'h8000_0000, 32'h0, 32'hFFFF_8765, 1'b0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      out_ready     = 1'b0;
      mem_rvalid    = 1'b1;
      mem_rdata     = 32'h1234_8765;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hFFFF_FFFF;
      e = sb_q.pop_front();
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (out_valid !== 1'b1 || rd_data !== e.rd || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d got ov=%b rd=%h rdy=%b want 1 %h 0",
                     i, out_valid, rd_data, in_ready, e.rd);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release got ov=%b rdy=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_inflight;
      issue(4'h3, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
      sb_q.delete();
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
          rd_data !== 32'h0 || mem_addr !== 32'h0) begin
         fails++;
         $display("FAIL rst_flight got rdy=%b ov=%b rq=%b rd=%h a=%h want 1 0 0 0 0",
                  in_ready, out_valid, mem_req_valid, rd_data, mem_addr);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hA5A5_A5A5;
      @(negedge clk);
      mem_rvalid = 1'b0;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd_data !== 32'h0) begin
         fails++;
         $display("FAIL rst_late_resp got ov=%b rdy=%b rd=%h want 0 1 0",
                  out_valid, in_ready, rd_data);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] v;
      for (int k = 0; k < 6; k++) begin
         v = $urandom;
         tests++;
         if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready%0d got %b want 1", k, in_ready);
         end
         issue(4'h0, v, 32'h0, v, 1'b0);
         e = sb_q.pop_front();
         tests++;
         if (out_valid !== 1'b1 || rd_data !== e.rd || misalign !== e.mis) begin
            fails++;
            $display("FAIL b2b_out%0d got ov=%b rd=%h mis=%b want 1 %h %b",
                     k, out_valid, rd_data, misalign, e.rd, e.mis);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst           = 1'b1;
      in_valid      = 1'b0;
      lsu_op        = 4'h0;
      alu_result    = 32'h0;
      rs2_data      = 32'h0;
      out_ready     = 1'b1;
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = 32'h0;
      mem_bvalid    = 1'b0;
      @(negedge clk);
      test_reset();
      test_none();
      test_loads();
      test_store();
      test_misalign();
      test_backpressure();
      test_reset_inflight();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
